uart_rx_variable: RTL and testbench

UART_RX_VARIABLE -- requirements
Module: uart_rx_variable

---
 rtl/uart_rx_variable.sv | 153 +++++++++++++++
 tb/tb_uart_rx_variable.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_variable.sv
// rtl/uart_rx_variable.sv - 8N1 UART receiver with per-frame latched clocks-per-bit period
module uart_rx_variable #(
    parameter int unsigned DEFAULT_PERIOD = 217,
    parameter int unsigned MIN_PERIOD     = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [19:0] i_Period,
    input  logic        i_UART_RX,
    output logic        o_RX_DV,
    output logic [7:0]  o_RX_Byte,
    output logic        o_Frame_Err,
    output logic        o_Busy
);

    localparam logic [19:0] DEF_P = 20'(DEFAULT_PERIOD);
    localparam logic [19:0] MIN_P = 20'(MIN_PERIOD);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [19:0] r_cnt;
    logic [2:0]  r_bit;
    logic [19:0] r_period;
    logic [7:0]  r_shift;
    logic [7:0]  r_byte;
    logic        r_dv;
    logic        r_fe;

    logic        w_rx_s;
    logic [19:0] w_half;
    logic [19:0] w_last;
    logic        w_cnt_clr;
    logic        w_load_p;
    logic        w_shift;
    logic        w_dv;
    logic        w_fe;

    assign w_rx_s = r_sync2;
    assign w_half = (r_period - 20'd1) >> 1;
    assign w_last = r_period - 20'd1;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_UART_RX;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // START samples mid-bit; DATA/STOP then sample one full period apart
    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_load_p     = 1'b0;
        w_shift      = 1'b0;
        w_dv         = 1'b0;
        w_fe         = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rx_s) begin
                    w_load_p     = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                if (r_cnt == w_half) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == w_last) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (r_cnt == w_last) begin
                    w_cnt_clr = 1'b1;
                    if (w_rx_s) begin
                        w_dv         = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_fe         = 1'b1;
                        w_next_state = BREAK;
                    end
                end
            end
            BREAK: begin
                w_cnt_clr = 1'b1;
                if (w_rx_s) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_cnt_clr    = 1'b1;
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_cnt    <= 20'd0;
            r_bit    <= 3'd0;
            r_period <= 20'd0;
            r_shift  <= 8'h00;
            r_byte   <= 8'h00;
            r_dv     <= 1'b0;
            r_fe     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clr ? 20'd0 : r_cnt + 20'd1;
            r_dv  <= w_dv;
            r_fe  <= w_fe;
            // Period is captured only at the start edge so baud changes wait for the next frame
            if (w_load_p) begin
                r_period <= (i_Period < MIN_P) ? DEF_P : i_Period;
                r_bit    <= 3'd0;
            end
            if (w_shift) begin
                r_shift[r_bit] <= w_rx_s;
                r_bit          <= r_bit + 3'd1;
            end
            if (w_dv) begin
                r_byte <= r_shift;
            end
        end
    end

    assign o_RX_DV     = r_dv;
    assign o_Frame_Err = r_fe;
    assign o_RX_Byte   = r_byte;
    assign o_Busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_variable.sv
// tb/tb_uart_rx_variable.sv - directed self-checking bench for uart_rx_variable
module tb_uart_rx_variable;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] period;
    logic        rx;
    logic        dv;
    logic [7:0]  rx_byte;
    logic        fe;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int dv_cyc = -1;
    int fe_cnt = 0;
    int fe_cyc = -1;
    int both_cnt = 0;
    int busy_rise = -1;
    logic       busy_q = 1'b0;
    logic [7:0] dv_byte = 8'h00;

    uart_rx_variable #(.DEFAULT_PERIOD(217), .MIN_PERIOD(4)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Period    (period),
        .i_UART_RX   (rx),
        .o_RX_DV     (dv),
        .o_RX_Byte   (rx_byte),
        .o_Frame_Err (fe),
        .o_Busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv) begin
            dv_cnt++;
            dv_cyc  = cyc;
            dv_byte = rx_byte;
        end
        if (fe) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (dv && fe) both_cnt++;
        if (busy && !busy_q) busy_rise = cyc;
        busy_q = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v, input int p);
        rx = v;
        repeat (p) @(negedge clk);
    endtask

    // Start edge on the line reaches the FSM three edges later (2-flop sync + state edge)
    task automatic send_frame(input logic [7:0] d, input int p, input logic stopv,
                              input int chg_bit, input logic [19:0] chg_val, output int t0);
        t0 = cyc + 3;
        send_bit(1'b0, p);
        for (int k = 0; k < 8; k++) begin
            if (k == chg_bit) period = chg_val;
            send_bit(d[k], p);
        end
        send_bit(stopv, p);
    endtask

    initial begin
        int t0;
        int c;
        rst_n  = 1'b0;
        rx     = 1'b1;
        period = 20'd217;
        repeat (5) @(negedge clk);
        chk("reset_dv", {31'd0, dv}, 32'd0);
        chk("reset_fe", {31'd0, fe}, 32'd0);
        chk("reset_byte", {24'd0, rx_byte}, 32'h00);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'h37, 217, 1'b1, 8, 20'd0, t0);
        repeat (10) @(negedge clk);
        chk("f37_busy_rise", busy_rise, t0);
        chk("f37_dv_cnt", dv_cnt, 1);
        chk("f37_dv_cyc", dv_cyc, t0 + 2062);
        chk("f37_dv_byte", {24'd0, dv_byte}, 32'h37);
        chk("f37_byte_held", {24'd0, rx_byte}, 32'h37);
        chk("f37_fe_cnt", fe_cnt, 0);
        chk("f37_busy_idle", {31'd0, busy}, 32'd0);

        send_frame(8'h00, 217, 1'b0, 8, 20'd0, t0);
        repeat (3000 - 217) @(negedge clk);
        chk("ferr_fe_cnt", fe_cnt, 1);
        chk("ferr_fe_cyc", fe_cyc, t0 + 2062);
        chk("ferr_dv_cnt", dv_cnt, 1);
        chk("ferr_byte_kept", {24'd0, rx_byte}, 32'h37);
        chk("ferr_busy_break", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("ferr_busy_pre_release", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("ferr_busy_released", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);

        c  = cyc;
        t0 = c + 3;
        rx = 1'b0;
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (61) @(negedge clk);
        chk("glitch_busy_t0_108", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("glitch_busy_t0_109", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        chk("glitch_dv_cnt", dv_cnt, 1);
        chk("glitch_fe_cnt", fe_cnt, 1);

        send_frame(8'h41, 217, 1'b1, 8, 20'd0, t0);
        repeat (10) @(negedge clk);
        chk("f41_dv_cnt", dv_cnt, 2);
        chk("f41_dv_cyc", dv_cyc, t0 + 2062);
        chk("f41_byte", {24'd0, rx_byte}, 32'h41);

        send_frame(8'h5A, 217, 1'b1, 3, 20'd434, t0);
        repeat (10) @(negedge clk);
        chk("f5a_dv_cnt", dv_cnt, 3);
        chk("f5a_dv_cyc", dv_cyc, t0 + 2062);
        chk("f5a_byte", {24'd0, rx_byte}, 32'h5A);

        send_frame(8'hC3, 434, 1'b1, 8, 20'd0, t0);
        repeat (10) @(negedge clk);
        chk("fc3_dv_cnt", dv_cnt, 4);
        chk("fc3_dv_cyc", dv_cyc, t0 + 4123);
        chk("fc3_byte", {24'd0, rx_byte}, 32'hC3);

        period = 20'd0;
        send_frame(8'hA5, 217, 1'b1, 8, 20'd0, t0);
        repeat (10) @(negedge clk);
        chk("fa5_dv_cnt", dv_cnt, 5);
        chk("fa5_dv_cyc", dv_cyc, t0 + 2062);
        chk("fa5_byte", {24'd0, rx_byte}, 32'hA5);

        period = 20'd217;
        send_bit(1'b0, 217);
        rx = 1'b1;
        repeat (500) @(negedge clk);
        chk("rst_busy_in_data", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_byte", {24'd0, rx_byte}, 32'h00);
        chk("rst_mid_dv", {31'd0, dv}, 32'd0);
        chk("rst_mid_fe", {31'd0, fe}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        chk("rst_no_strobe_dv", dv_cnt, 5);
        chk("rst_no_strobe_fe", fe_cnt, 1);

        send_frame(8'h12, 217, 1'b1, 8, 20'd0, t0);
        repeat (10) @(negedge clk);
        chk("f12_dv_cnt", dv_cnt, 6);
        chk("f12_dv_cyc", dv_cyc, t0 + 2062);
        chk("f12_byte", {24'd0, rx_byte}, 32'h12);
        chk("never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
